// File: rtl/invaders_controller_pkg.sv
// Shared constants, state encoding and helpers for the invaders controller.
package invaders_controller_pkg;

  localparam int INV_COLS = 20;
  localparam int LINE_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam logic [INV_COLS-1:0] DEF_INIT_ARRAY = 20'b00101010101010101010;
  localparam logic [LINE_W-1:0]   DEF_INIT_LINE  = 5'd4;
  localparam logic [LINE_W-1:0]   DEF_SHIP_LINE  = 5'd14;

  // One-hot column mask; columns >= INV_COLS produce an all-zero mask.
  function automatic logic [INV_COLS-1:0] col_mask(input logic [4:0] col);
    logic [31:0] m;
    m = 32'd1 << col;
    return m[INV_COLS-1:0];
  endfunction

endpackage

// File: rtl/invaders_controller_step_timer.sv
// Descent step timer: counts enabled cycles and pulses tick once every
// STEP_CYCLES enabled cycles, on the cycle the count wraps to zero.
module step_timer #(
  parameter int unsigned STEP_CYCLES = 36000000
) (
  input  logic clk_36MHz,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && !clr && (cnt_q == LAST);

  // Count enabled cycles, wrapping at LAST; clr holds the count at zero.
  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      if (cnt_q == LAST) cnt_q <= '0;
      else               cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/invaders_controller.sv
// Invaders wave controller: descends the invader row on a timer, clears
// invaders hit by the bullet, and decides whether the wave is won or lost.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; array/line parked at their initial values
//   PLAY  | wave in progress; timer descends the row, bullets destroy cells
//   WON   | every invader destroyed; array/line frozen, wave_cleared high
//   LOST  | row reached the ship line with invaders left; game_over high
module invaders_controller
  import invaders_controller_pkg::*;
#(
  parameter int unsigned          STEP_CYCLES = 36000000,
  parameter logic [INV_COLS-1:0]  INIT_ARRAY  = DEF_INIT_ARRAY,
  parameter logic [LINE_W-1:0]    INIT_LINE   = DEF_INIT_LINE,
  parameter logic [LINE_W-1:0]    SHIP_LINE   = DEF_SHIP_LINE
) (
  input  logic                clk_36MHz,
  input  logic                reset,
  input  logic                start_debounced,
  input  logic                clear,
  input  logic                enable,
  input  logic [4:0]          bullet_x,
  input  logic [3:0]          bullet_y,
  input  logic                bullet_flying,
  output logic [INV_COLS-1:0] invaders_array,
  output logic [LINE_W-1:0]   invaders_line,
  output logic                hit,
  output logic                game_over,
  output logic                wave_cleared
);

  state_t              state_q;
  logic [INV_COLS-1:0] array_q, array_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                hit_q, hit_d;
  logic                game_over_q;
  logic                wave_cleared_q;

  logic                play_en;
  logic                step_tick;
  logic [31:0]         array_ext;

  assign play_en   = (state_q == PLAY) && enable;
  assign array_ext = 32'(array_q);

  step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_step_timer (
    .clk_36MHz (clk_36MHz),
    .reset     (reset),
    .clr       ((state_q != PLAY) || clear),
    .en        (play_en),
    .tick      (step_tick)
  );

  // Hit qualification uses the row as it stands before any step this cycle.
  always_comb begin
    hit_d   = play_en && bullet_flying
              && (bullet_x < 5'(INV_COLS))
              && ({1'b0, bullet_y} == line_q)
              && array_ext[bullet_x];
    array_d = hit_d ? (array_q & ~col_mask(bullet_x)) : array_q;
    line_d  = step_tick ? (line_q + 5'd1) : line_q;
  end

  // Game state machine with registered array, row and flag outputs.
  always_ff @(posedge clk_36MHz or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      array_q        <= INIT_ARRAY;
      line_q         <= INIT_LINE;
      hit_q          <= 1'b0;
      game_over_q    <= 1'b0;
      wave_cleared_q <= 1'b0;
    end else if (clear) begin
      state_q        <= IDLE;
      array_q        <= INIT_ARRAY;
      line_q         <= INIT_LINE;
      hit_q          <= 1'b0;
      game_over_q    <= 1'b0;
      wave_cleared_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          hit_q <= 1'b0;
          if (start_debounced) begin
            state_q <= PLAY;
            array_q <= INIT_ARRAY;
            line_q  <= INIT_LINE;
          end
        end
        PLAY: begin
          // hit_d/step_tick are gated by enable, so a low enable freezes all.
          hit_q   <= hit_d;
          array_q <= array_d;
          line_q  <= line_d;
          // An emptied array wins even if the same step reaches the ship.
          if (array_d == '0) begin
            state_q        <= WON;
            wave_cleared_q <= 1'b1;
          end else if (step_tick && (line_d == SHIP_LINE)) begin
            state_q     <= LOST;
            game_over_q <= 1'b1;
          end
        end
        WON, LOST: begin
          hit_q <= 1'b0;
          if (start_debounced) begin
            state_q        <= PLAY;
            array_q        <= INIT_ARRAY;
            line_q         <= INIT_LINE;
            game_over_q    <= 1'b0;
            wave_cleared_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          hit_q   <= 1'b0;
        end
      endcase
    end
  end

  assign invaders_array = array_q;
  assign invaders_line  = line_q;
  assign hit            = hit_q;
  assign game_over      = game_over_q;
  assign wave_cleared   = wave_cleared_q;

endmodule

// File: tb/tb_invaders_controller.sv
// Directed bench for invaders_controller with a 4-cycle descent step.
module tb_invaders_controller;

  localparam logic [19:0] INIT = 20'b00101010101010101010;

  logic        clk_36MHz = 1'b0;
  logic        reset;
  logic        start_debounced;
  logic        clear;
  logic        enable;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic        bullet_flying;
  logic [19:0] invaders_array;
  logic [4:0]  invaders_line;
  logic        hit;
  logic        game_over;
  logic        wave_cleared;

  int          errors = 0;
  int          checks = 0;
  int          k      = 0;
  logic [19:0] arr_exp;

  invaders_controller #(
    .STEP_CYCLES (4)
  ) dut (
    .clk_36MHz       (clk_36MHz),
    .reset           (reset),
    .start_debounced (start_debounced),
    .clear           (clear),
    .enable          (enable),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .bullet_flying   (bullet_flying),
    .invaders_array  (invaders_array),
    .invaders_line   (invaders_line),
    .hit             (hit),
    .game_over       (game_over),
    .wave_cleared    (wave_cleared)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_36MHz);
    #1;
  endtask

  // One enabled PLAY cycle; k counts them since the last start.
  task automatic play_cyc();
    cyc();
    k++;
  endtask

  // Row before the edge about to happen: one step per 4 enabled cycles.
  function automatic int line_exp();
    return 4 + k / 4;
  endfunction

  task automatic shoot(input int x, input string tag);
    bullet_x      = 5'(x);
    bullet_y      = 4'(line_exp());
    bullet_flying = 1'b1;
    play_cyc();
    arr_exp[x] = 1'b0;
    check({tag, "_hit"}, 32'(hit), 32'd1);
    check({tag, "_array"}, 32'(invaders_array), 32'(arr_exp));
    bullet_flying = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_debounced = 1'b0; clear = 1'b0; enable = 1'b1;
    bullet_x = '0; bullet_y = '0; bullet_flying = 1'b0;
    #12;
    check("rst_array", 32'(invaders_array), 32'(INIT));
    check("rst_line",  32'(invaders_line), 32'd4);
    check("rst_hit",   32'(hit), 32'd0);
    check("rst_go",    32'(game_over), 32'd0);
    check("rst_wc",    32'(wave_cleared), 32'd0);
    @(negedge clk_36MHz); reset = 1'b0;

    // No start: stays parked even with enable high.
    repeat (5) cyc();
    check("idle_no_start_line", 32'(invaders_line), 32'd4);

    // Game 1: let the row descend to the ship line.
    start_debounced = 1'b1; cyc(); start_debounced = 1'b0; k = 0;
    check("start_line",  32'(invaders_line), 32'd4);
    check("start_array", 32'(invaders_array), 32'(INIT));
    repeat (4) play_cyc();
    check("step_4_line", 32'(invaders_line), 32'd5);
    while (k < 39) play_cyc();
    check("step_39_line", 32'(invaders_line), 32'd13);
    check("step_39_go",   32'(game_over), 32'd0);
    play_cyc();
    check("lost_line", 32'(invaders_line), 32'd14);
    check("lost_go",   32'(game_over), 32'd1);
    check("lost_wc",   32'(wave_cleared), 32'd0);
    repeat (2) cyc();
    check("lost_hold_line", 32'(invaders_line), 32'd14);
    check("lost_hold_go",   32'(game_over), 32'd1);

    // Clear from LOST.
    clear = 1'b1; cyc(); clear = 1'b0;
    check("clr_go",    32'(game_over), 32'd0);
    check("clr_line",  32'(invaders_line), 32'd4);
    check("clr_array", 32'(invaders_array), 32'(INIT));
    check("clr_wc",    32'(wave_cleared), 32'd0);
    check("clr_hit",   32'(hit), 32'd0);

    // Game 2: hits, enable gating, start ignored, last hit on final step.
    start_debounced = 1'b1; cyc(); start_debounced = 1'b0; k = 0;
    arr_exp = INIT;
    bullet_x = 5'd2; bullet_y = 4'd4; bullet_flying = 1'b1;
    play_cyc();
    check("miss_empty_hit",   32'(hit), 32'd0);
    check("miss_empty_array", 32'(invaders_array), 32'(arr_exp));
    bullet_x = 5'd3;
    play_cyc();
    arr_exp[3] = 1'b0;
    check("hit3_hit",   32'(hit), 32'd1);
    check("hit3_array", 32'(invaders_array), 32'(arr_exp));
    play_cyc();
    check("hit3_once_a", 32'(hit), 32'd0);
    play_cyc();
    check("hit3_once_b", 32'(hit), 32'd0);
    check("k4_line",     32'(invaders_line), 32'd5);
    bullet_flying = 1'b0;

    enable = 1'b0;
    bullet_x = 5'd5; bullet_y = 4'd5; bullet_flying = 1'b1;
    repeat (10) begin
      cyc();
      check("dis_hit", 32'(hit), 32'd0);
    end
    check("dis_line",  32'(invaders_line), 32'd5);
    check("dis_array", 32'(invaders_array), 32'(arr_exp));
    enable = 1'b1;
    play_cyc();
    arr_exp[5] = 1'b0;
    check("hit5_hit",   32'(hit), 32'd1);
    check("hit5_array", 32'(invaders_array), 32'(arr_exp));
    bullet_flying = 1'b0;
    repeat (2) play_cyc();
    check("k7_line", 32'(invaders_line), 32'd5);
    play_cyc();
    check("k8_line", 32'(invaders_line), 32'd6);

    start_debounced = 1'b1; play_cyc(); start_debounced = 1'b0;
    check("play_start_array", 32'(invaders_array), 32'(arr_exp));
    check("play_start_line",  32'(invaders_line), 32'd6);

    shoot(1,  "hit1");
    shoot(7,  "hit7");
    shoot(9,  "hit9_with_step");
    shoot(11, "hit11");
    shoot(13, "hit13");
    shoot(15, "hit15");
    check("k15_line", 32'(invaders_line), 32'd7);
    while (k < 39) play_cyc();
    check("k39_line",  32'(invaders_line), 32'd13);
    check("k39_array", 32'(invaders_array), 32'h20000);
    check("k39_go",    32'(game_over), 32'd0);
    shoot(17, "hit17_last");
    check("won_wc",   32'(wave_cleared), 32'd1);
    check("won_go",   32'(game_over), 32'd0);
    check("won_line", 32'(invaders_line), 32'd14);
    cyc();
    check("won_hit_drop", 32'(hit), 32'd0);
    bullet_x = 5'd1; bullet_y = 4'd14; bullet_flying = 1'b1;
    cyc();
    check("won_bullet_hit", 32'(hit), 32'd0);
    check("won_hold_line",  32'(invaders_line), 32'd14);
    check("won_hold_wc",    32'(wave_cleared), 32'd1);
    bullet_flying = 1'b0;

    // Restart from WON, then reset while a hit pulse is showing.
    start_debounced = 1'b1; cyc(); start_debounced = 1'b0; k = 0;
    check("restart_wc",    32'(wave_cleared), 32'd0);
    check("restart_array", 32'(invaders_array), 32'(INIT));
    bullet_x = 5'd3; bullet_y = 4'd4; bullet_flying = 1'b1;
    play_cyc();
    check("pre_rst_hit", 32'(hit), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_hit",   32'(hit), 32'd0);
    check("mid_rst_array", 32'(invaders_array), 32'(INIT));
    check("mid_rst_line",  32'(invaders_line), 32'd4);
    check("mid_rst_go",    32'(game_over), 32'd0);
    check("mid_rst_wc",    32'(wave_cleared), 32'd0);
    bullet_flying = 1'b0;
    @(negedge clk_36MHz); reset = 1'b0;

    // clear beats start; a lone start afterwards does begin play.
    start_debounced = 1'b1; clear = 1'b1; cyc();
    start_debounced = 1'b0; clear = 1'b0;
    repeat (4) cyc();
    check("clr_prio_line", 32'(invaders_line), 32'd4);
    start_debounced = 1'b1; cyc(); start_debounced = 1'b0;
    repeat (4) cyc();
    check("post_rst_play_line", 32'(invaders_line), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
